// File: rtl/ctrl_trace_buffer.sv
// Run-length compressing trace buffer for the microprogram controller's control word.
// Pending run is held in a 2-state FSM; finished runs queue in a FIFO drained over valid/ready.
module ctrl_trace_buffer #(
  parameter int CW_W        = 39,
  parameter int RL_W        = 8,
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int CHANGE_ONLY = 1,
  parameter int DROP_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CW_W-1:0]      cw_in,
  input  logic                 cw_valid,
  input  logic                 flush,
  input  logic                 trace_ready,
  output logic [RL_W+CW_W-1:0] trace_data,
  output logic                 trace_valid,
  output logic [AW:0]          fifo_level,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_cnt,
  output logic                 busy
);

  localparam int                ENT_W    = RL_W + CW_W;
  localparam logic [RL_W-1:0]   RUN_MAX  = '1;
  localparam logic [AW:0]       FULL_LVL = DEPTH[AW:0];
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state;
  logic [CW_W-1:0]   r_pend;
  logic [RL_W-1:0]   r_run;
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_level;
  logic [DROP_W-1:0] r_drop;
  logic              r_ovf;

  logic             w_merge;
  logic             w_emit;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [ENT_W-1:0] w_entry;

  // A flush alongside a new word forces the old run out even if the word matches.
  always_comb begin
    w_merge = 1'b0;
    w_emit  = 1'b0;
    w_entry = {r_run, r_pend};
    if ((CHANGE_ONLY != 0) && !flush && (cw_in == r_pend) && (r_run != RUN_MAX)) begin
      w_merge = 1'b1;
    end else begin
      w_merge = 1'b0;
    end
    if (r_state == S_RUN) begin
      if (cw_valid) begin
        w_emit = !w_merge;
      end else begin
        w_emit = flush;
      end
    end else begin
      w_emit = 1'b0;
    end
  end

  assign w_pop  = (r_level != '0) && trace_ready;
  assign w_push = w_emit && ((r_level != FULL_LVL) || w_pop);
  assign w_drop = w_emit && !w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_run   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cw_valid) begin
            r_state <= S_RUN;
            r_pend  <= cw_in;
            r_run   <= RL_W'(1);
          end
        end
        S_RUN: begin
          if (cw_valid) begin
            if (w_merge) begin
              r_run <= r_run + RL_W'(1);
            end else begin
              r_pend <= cw_in;
              r_run  <= RL_W'(1);
            end
          end else if (flush) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage needs no reset: pointers and level alone define what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != DROP_MAX) begin
          r_drop <= r_drop + DROP_W'(1);
        end
      end
    end
  end

  assign trace_valid = (r_level != '0);
  assign trace_data  = trace_valid ? r_mem[r_rptr] : '0;
  assign fifo_level  = r_level;
  assign overflow    = r_ovf;
  assign drop_cnt    = r_drop;
  assign busy        = (r_state == S_RUN) || (r_level != '0);

endmodule

// File: tb/tb_ctrl_trace_buffer.sv
// Scoreboard bench for ctrl_trace_buffer: a behavioural model predicts emitted entries,
// pops are compared in order, plus directed checks and a CHANGE_ONLY=0 instance.
module tb_ctrl_trace_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [38:0] cw_in = '0;
  logic        cw_valid = 1'b0;
  logic        flush = 1'b0;
  logic        trace_ready = 1'b0;
  logic [46:0] trace_data;
  logic        trace_valid;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        busy;

  logic [38:0] cw_in0 = '0;
  logic        cw_valid0 = 1'b0;
  logic        flush0 = 1'b0;
  logic        ready0 = 1'b0;
  logic [46:0] data0;
  logic        valid0;
  logic [3:0]  level0;
  logic        ovf0;
  logic [15:0] drop0;
  logic        busy0;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [38:0] W1 = 39'h40_0000_0006;
  localparam logic [38:0] W2 = 39'h00_0000_0040;
  localparam logic [38:0] W3 = 39'h12_3456_789A;
  localparam logic [38:0] W6 = 39'h05_5555_0003;

  ctrl_trace_buffer dut (
    .clk(clk), .rst(rst), .cw_in(cw_in), .cw_valid(cw_valid), .flush(flush),
    .trace_ready(trace_ready), .trace_data(trace_data), .trace_valid(trace_valid),
    .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt), .busy(busy)
  );

  ctrl_trace_buffer #(.CHANGE_ONLY(0)) dut0 (
    .clk(clk), .rst(rst), .cw_in(cw_in0), .cw_valid(cw_valid0), .flush(flush0),
    .trace_ready(ready0), .trace_data(data0), .trace_valid(valid0),
    .fifo_level(level0), .overflow(ovf0), .drop_cnt(drop0), .busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of the main instance (CHANGE_ONLY=1, DEPTH=8, RL max 255)
  logic [46:0] exp_q[$];
  bit          m_run_st = 1'b0;
  logic [38:0] m_pend = '0;
  int          m_run = 0;
  int          m_drop = 0;
  bit          m_ovf = 1'b0;

  always @(negedge clk) begin
    int          lvl;
    bit          pop;
    bit          emit;
    logic [46:0] ent;
    if (rst) begin
      exp_q.delete();
      m_run_st = 1'b0;
      m_pend   = '0;
      m_run    = 0;
      m_drop   = 0;
      m_ovf    = 1'b0;
    end else begin
      lvl = exp_q.size();
      check("level", 64'(fifo_level), 64'(lvl));
      check("valid", 64'(trace_valid), 64'(lvl != 0));
      check("drop", 64'(drop_cnt), 64'(m_drop));
      check("ovf", 64'(overflow), 64'(m_ovf));
      check("busy", 64'(busy), 64'(m_run_st || lvl != 0));
      pop  = (lvl != 0) && trace_ready;
      emit = 1'b0;
      ent  = {m_run[7:0], m_pend};
      if (!m_run_st) begin
        if (cw_valid) begin
          m_run_st = 1'b1;
          m_pend   = cw_in;
          m_run    = 1;
        end
      end else if (cw_valid) begin
        if (!flush && cw_in == m_pend && m_run < 255) begin
          m_run++;
        end else begin
          emit   = 1'b1;
          m_pend = cw_in;
          m_run  = 1;
        end
      end else if (flush) begin
        emit     = 1'b1;
        m_run_st = 1'b0;
      end
      if (pop) begin
        check("pop_data", 64'(trace_data), 64'(exp_q.pop_front()));
      end
      if (emit) begin
        if (lvl < 8 || pop) begin
          exp_q.push_back(ent);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [38:0] w, input bit f);
    cw_valid = v;
    cw_in    = w;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic step0();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_valid", 64'(trace_valid), 64'd0);
    check("rst_data", 64'(trace_data), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // 1: three equal words then a new one
    trace_ready = 1'b1;
    repeat (3) drive(1'b1, W1, 1'b0);
    check("t1_early", 64'(trace_valid), 64'd0);
    drive(1'b1, W2, 1'b0);
    check("t1_valid", 64'(trace_valid), 64'd1);
    check("t1_data", 64'(trace_data), 64'({8'd3, W1}));
    drive(1'b0, '0, 1'b1);
    repeat (3) drive(1'b0, '0, 1'b0);

    // 2: 256 identical words then flush
    repeat (256) drive(1'b1, W3, 1'b0);
    drive(1'b0, '0, 1'b1);
    check("t2_busy_flush", 64'(busy), 64'd1);
    repeat (4) drive(1'b0, '0, 1'b0);
    check("t2_busy_drain", 64'(busy), 64'd0);

    // 3: sink stalled, ten distinct words
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) drive(1'b1, 39'h100 + 39'(i), 1'b0);
    check("t3_level", 64'(fifo_level), 64'd8);
    check("t3_drop", 64'(drop_cnt), 64'd1);
    check("t3_ovf", 64'(overflow), 64'd1);

    // 4: full FIFO, emit and pop together
    trace_ready = 1'b1;
    drive(1'b1, 39'h7AB, 1'b0);
    check("t4_level", 64'(fifo_level), 64'd8);
    check("t4_drop", 64'(drop_cnt), 64'd1);
    drive(1'b0, '0, 1'b1);
    repeat (12) drive(1'b0, '0, 1'b0);
    check("t4_drained", 64'(fifo_level), 64'd0);

    // 5: reset while running with three queued entries
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 39'h200 + 39'(i), 1'b0);
    check("t5_pre_level", 64'(fifo_level), 64'd3);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    rst = 1'b0;
    check("t5_level", 64'(fifo_level), 64'd0);
    check("t5_valid", 64'(trace_valid), 64'd0);
    check("t5_drop", 64'(drop_cnt), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    trace_ready = 1'b1;
    repeat (4) drive(1'b0, '0, 1'b0);

    // 6: CHANGE_ONLY=0 instance, four identical strobes
    cw_valid0 = 1'b1;
    cw_in0    = W6;
    repeat (4) step0();
    cw_valid0 = 1'b0;
    check("t6_level", 64'(level0), 64'd3);
    check("t6_head", 64'(data0), 64'({8'd1, W6}));
    check("t6_busy", 64'(busy0), 64'd1);
    flush0 = 1'b1;
    step0();
    flush0 = 1'b0;
    check("t6_flush_level", 64'(level0), 64'd4);
    ready0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t6_drain_valid", 64'(valid0), 64'd1);
      check("t6_drain_data", 64'(data0), 64'({8'd1, W6}));
      step0();
    end
    check("t6_empty", 64'(level0), 64'd0);
    check("t6_idle", 64'(busy0), 64'd0);
    check("t6_drop", 64'(drop0), 64'd0);
    check("t6_ovf", 64'(ovf0), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
